gshare_btb_predictor: RTL and testbench
=======================================

# gshare_btb_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined RV32I core. It sits beside the PC register: the IF stage looks up the current PC each cycle and receives a predicted next PC; the EX stage reports resolved control-flow instructions back for training. It replaces the fixed "PC+4, fix up later" fetch policy with a tagged BTB, a table of saturating counters (gshare or bimodal indexing) and a global history register. It also keeps saturating performance counters.

## Interface
Parameters:
- XLEN, 32, address/data width
- IDX_BITS, 5, log2 of table entries (BTB and PHT both have 2^IDX_BITS entries)
- GHR_BITS, 5, global history length; legal range 1..IDX_BITS
- CTR_BITS, 2, PHT counter width; legal range 1..4
- USE_GSHARE, 1, 1 = PHT index is PC index XOR history; 0 = bimodal (PC index only)
- CNT_BITS, 16, performance counter width

Ports (reset: synchronous, active-high; clock: clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pc  in  XLEN  IF-stage fetch PC
- pred_taken  out  1  lookup predicts redirect
- pred_target  out  XLEN  BTB target on hit, else 0
- next_pc  out  XLEN  pred_taken ? pred_target : pc+4
- upd_valid  in  1  EX reports a resolved instruction this cycle
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_is_branch  in  1  conditional branch
- upd_is_jump  in  1  jal/jalr
- upd_taken  in  1  actual outcome (jumps: always 1)
- upd_target  in  XLEN  actual target
- upd_mispredict  in  1  pipeline flushed for this instruction
- branch_count  out  CNT_BITS  resolved branches+jumps
- mispredict_count  out  CNT_BITS  mispredicts

## Operation
- Fields: pidx = pc[IDX_BITS+1:2]; tag = pc[XLEN-1:IDX_BITS+2]; the same rules apply to upd_pc.
- PHT index: USE_GSHARE ? pidx ^ zero-extended GHR : pidx. The update-side index uses the current (pre-update) GHR.
- BTB entry: valid, tag, target, jump flag. The BTB is indexed by pidx only.
- Lookup (combinational): hit = valid & tag match.
  - pred_taken = hit & (jump flag | PHT[index] MSB).
  - pred_target = hit ? target : 0.
  - next_pc wraps modulo 2^XLEN.
- Update applies when upd_valid & (upd_is_branch | upd_is_jump):
  - If upd_taken: write the BTB entry at the upd pidx: valid=1, tag, target=upd_target, jump flag=upd_is_jump. This overwrites any aliasing entry.
  - Not-taken branches leave the BTB untouched.
  - upd_is_branch: the PHT counter increments if taken, else decrements. It saturates at 2^CTR_BITS-1 and at 0.
  - upd_is_branch: GHR <= {GHR[GHR_BITS-2:0], upd_taken}; for GHR_BITS=1, GHR <= upd_taken. Jumps do not shift the GHR.
  - USE_GSHARE=0 still maintains the GHR.
  - If both upd_is_branch and upd_is_jump are set, the instruction is treated as a jump. No PHT or GHR change occurs; the BTB is written only if upd_taken.
- Counters:
  - branch_count +1 on each qualifying update.
  - mispredict_count +1 when upd_mispredict is set on a qualifying update.
  - Both saturate at all-ones and never wrap.
  - upd_mispredict is ignored when the update does not qualify.
- upd_valid=0: no state changes.

## Timing
- Lookup has zero latency: outputs are a combinational function of pc and registered state.
- Updates are written at posedge. A same-cycle lookup of the entry being updated returns the old contents. The new contents are visible the cycle after.
- Reset values, applied at the posedge with reset=1:
  - All BTB valid bits = 0.
  - All PHT counters = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for CTR_BITS=2).
  - GHR = 0; both counters = 0.
  - Hence pred_taken=0, pred_target=0, next_pc=pc+4 from the first cycle after reset.
- Reset overrides a simultaneous update.
- Reset asserted mid-operation discards all training.

## Test plan
- Reset: pulse reset with upd_valid=1 (upd_pc 0x40, taken branch), then lookup pc=0x40 -> pred_taken=0, next_pc=0x44, both counters 0.
- Bimodal (USE_GSHARE=0) train: one taken branch update at 0x40 with target 0x20 -> PHT[0x10]=10; lookup 0x40 gives pred_taken=1, next_pc=0x20, branch_count=1.
- Gshare aliasing: same update with USE_GSHARE=1 -> GHR=00001; lookup 0x40 indexes PHT[0x11] (still 01) -> BTB hit but pred_taken=0, next_pc=0x44.
- Jump: jal update at 0x100 with target 0x200 -> the next-cycle lookup of 0x100 gives pred_taken=1, next_pc=0x200, GHR unchanged, PHT unchanged.
- Saturation (USE_GSHARE=0): four taken updates at 0x40 -> counter 11. One not-taken -> 10, still predicts taken. A second not-taken -> 01, pred_taken=0 while the BTB entry is still valid.
- Tag conflict and counters: train 0x40, then a taken update at 0xC0 with target 0x300 and upd_mispredict=1 -> lookup 0x40 misses (next_pc=0x44); lookup 0xC0 gives 0x300; mispredict_count=1. Force CNT_BITS=4 and issue 20 updates -> branch_count holds at 15.

Source files
------------

// File: rtl/gshare_btb_predictor.sv
// Dynamic branch predictor: tagged BTB plus a PHT of saturating counters (gshare or bimodal)
// with a global history register, trained from EX and looked up combinationally from IF.
module gshare_btb_predictor #(
    parameter int XLEN       = 32,
    parameter int IDX_BITS   = 5,
    parameter int GHR_BITS   = 5,
    parameter int CTR_BITS   = 2,
    parameter int USE_GSHARE = 1,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     pc,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_target,
    output logic [XLEN-1:0]     next_pc,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_is_branch,
    input  logic                upd_is_jump,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic                upd_mispredict,
    output logic [CNT_BITS-1:0] branch_count,
    output logic [CNT_BITS-1:0] mispredict_count
);
    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    typedef struct packed {
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
        logic                jump;
    } btb_entry_t;

    logic [ENTRIES-1:0]  btb_valid;
    btb_entry_t          btb [ENTRIES];
    logic [CTR_BITS-1:0] pht [ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_shifted;

    logic [IDX_BITS-1:0] ghr_ext;
    logic [IDX_BITS-1:0] look_idx;
    logic [IDX_BITS-1:0] look_pht_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [IDX_BITS-1:0] upd_pht_idx;
    logic                look_hit;
    logic                qualify;
    logic                cond_upd;
    logic                btb_write;
    logic                unused_low_bits;

    // Instructions are word aligned, so the byte-offset bits never select anything.
    assign unused_low_bits = ^{pc[1:0], upd_pc[1:0]};

    assign ghr_ext      = IDX_BITS'(ghr);
    assign look_idx     = pc[IDX_BITS+1:2];
    assign upd_idx      = upd_pc[IDX_BITS+1:2];
    assign look_pht_idx = (USE_GSHARE != 0) ? (look_idx ^ ghr_ext) : look_idx;
    assign upd_pht_idx  = (USE_GSHARE != 0) ? (upd_idx ^ ghr_ext) : upd_idx;

    assign look_hit    = btb_valid[look_idx] && (btb[look_idx].tag == pc[XLEN-1:IDX_BITS+2]);
    assign pred_taken  = look_hit && (btb[look_idx].jump || pht[look_pht_idx][CTR_BITS-1]);
    assign pred_target = look_hit ? btb[look_idx].target : '0;
    assign next_pc     = pred_taken ? pred_target : pc + XLEN'(4);

    // A branch flagged as a jump too trains like a jump: BTB only, history untouched.
    assign qualify   = upd_valid && (upd_is_branch || upd_is_jump);
    assign cond_upd  = qualify && upd_is_branch && !upd_is_jump;
    assign btb_write = qualify && upd_taken;

    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            assign ghr_shifted = upd_taken;
        end else begin : g_ghr_wide
            assign ghr_shifted = {ghr[GHR_BITS-2:0], upd_taken};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid        <= '0;
            ghr              <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else begin
            if (btb_write) begin
                btb_valid[upd_idx] <= 1'b1;
            end
            if (cond_upd) begin
                ghr <= ghr_shifted;
                if (upd_taken && pht[upd_pht_idx] != CTR_MAX) begin
                    pht[upd_pht_idx] <= pht[upd_pht_idx] + CTR_BITS'(1);
                end else if (!upd_taken && pht[upd_pht_idx] != '0) begin
                    pht[upd_pht_idx] <= pht[upd_pht_idx] - CTR_BITS'(1);
                end
            end
            if (qualify && branch_count != '1) begin
                branch_count <= branch_count + CNT_BITS'(1);
            end
            if (qualify && upd_mispredict && mispredict_count != '1) begin
                mispredict_count <= mispredict_count + CNT_BITS'(1);
            end
        end
    end

    // NOTE: BTB payload is not reset; the valid bits alone decide whether an entry is seen.
    always_ff @(posedge clk) begin
        if (btb_write) begin
            btb[upd_idx] <= '{tag: upd_pc[XLEN-1:IDX_BITS+2], target: upd_target, jump: upd_is_jump};
        end
    end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Scoreboard bench: a gshare instance and a bimodal instance (4-bit counters) share stimulus and
// are checked against an array-based reference model of the predictor rules.
module tb_gshare_btb_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    logic        pt_g, pt_b;
    logic [31:0] tg_g, tg_b, np_g, np_b;
    logic [15:0] bc_g, mc_g;
    logic [3:0]  bc_b, mc_b;

    always #5 clk = ~clk;

    gshare_btb_predictor #(
        .XLEN(32), .IDX_BITS(5), .GHR_BITS(5), .CTR_BITS(2), .USE_GSHARE(1), .CNT_BITS(16)
    ) dut_g (
        .clk(clk), .reset(reset), .pc(pc),
        .pred_taken(pt_g), .pred_target(tg_g), .next_pc(np_g),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict),
        .branch_count(bc_g), .mispredict_count(mc_g)
    );

    gshare_btb_predictor #(
        .XLEN(32), .IDX_BITS(5), .GHR_BITS(5), .CTR_BITS(2), .USE_GSHARE(0), .CNT_BITS(4)
    ) dut_b (
        .clk(clk), .reset(reset), .pc(pc),
        .pred_taken(pt_b), .pred_target(tg_b), .next_pc(np_b),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict),
        .branch_count(bc_b), .mispredict_count(mc_b)
    );

    // Index 0 = gshare instance, index 1 = bimodal instance.
    typedef struct packed {
        logic [31:0]      pc;
        logic [1:0]       tk;
        logic [1:0][31:0] tgt;
        logic [1:0][31:0] nxt;
        logic [1:0][31:0] brc;
        logic [1:0][31:0] mpc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model state: each BTB slot remembers the full PC that trained it.
    bit        m_valid [2][32];
    bit [31:0] m_pc    [2][32];
    bit [31:0] m_tgt   [2][32];
    bit        m_jmp   [2][32];
    int        m_pht   [2][32];
    int        m_ghr   [2];
    int        m_brc   [2];
    int        m_mpc   [2];

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                m_valid[k][i] = 1'b0;
                m_pht[k][i]   = 1;
            end
            m_ghr[k] = 0;
            m_brc[k] = 0;
            m_mpc[k] = 0;
        end
    endfunction

    task automatic predict(input int k, input bit [31:0] p,
                           output bit tk, output bit [31:0] tg, output bit [31:0] nx);
        int  i;
        int  pi;
        bit  hit;
        i   = int'((p >> 2) % 32);
        pi  = (k == 0) ? (i ^ m_ghr[k]) : i;
        hit = m_valid[k][i] && ((p >> 7) == (m_pc[k][i] >> 7));
        tk  = hit && (m_jmp[k][i] || m_pht[k][pi] >= 2);
        tg  = hit ? m_tgt[k][i] : 32'd0;
        nx  = tk ? tg : p + 32'd4;
    endtask

    task automatic model_update(input int k, input bit v, input bit [31:0] up, input bit b,
                                input bit j, input bit t, input bit [31:0] tgt, input bit m);
        int i;
        int pi;
        if (!(v && (b || j))) return;
        i  = int'((up >> 2) % 32);
        pi = (k == 0) ? (i ^ m_ghr[k]) : i;
        if (m_brc[k] < cnt_max(k)) m_brc[k]++;
        if (m && m_mpc[k] < cnt_max(k)) m_mpc[k]++;
        if (t) begin
            m_valid[k][i] = 1'b1;
            m_pc[k][i]    = up;
            m_tgt[k][i]   = tgt;
            m_jmp[k][i]   = j;
        end
        if (b && !j) begin
            if (t && m_pht[k][pi] < 3) m_pht[k][pi]++;
            if (!t && m_pht[k][pi] > 0) m_pht[k][pi]--;
            m_ghr[k] = ((m_ghr[k] << 1) | int'(t)) & 31;
        end
    endtask

    // Drive one cycle of stimulus; the expectation reflects state before this cycle's update.
    task automatic step(input bit rst, input bit [31:0] p, input bit v, input bit b, input bit j,
                        input bit t, input bit [31:0] tgt, input bit m);
        exp_t e;
        bit   tk;
        bit [31:0] tg, nx;
        @(posedge clk);
        #1;
        reset          = rst;
        pc             = p;
        upd_valid      = v;
        upd_pc         = p;
        upd_is_branch  = b;
        upd_is_jump    = j;
        upd_taken      = t;
        upd_target     = tgt;
        upd_mispredict = m;
        if (rst) begin
            model_reset();
        end else begin
            e.pc = p;
            for (int k = 0; k < 2; k++) begin
                predict(k, p, tk, tg, nx);
                e.tk[k]  = tk;
                e.tgt[k] = tg;
                e.nxt[k] = nx;
                e.brc[k] = 32'(m_brc[k]);
                e.mpc[k] = 32'(m_mpc[k]);
            end
            exp_q.push_back(e);
            for (int k = 0; k < 2; k++) model_update(k, v, p, b, j, t, tgt, m);
        end
    endtask

    // Lookup at address p while the update port trains a different address up.
    task automatic step2(input bit [31:0] p, input bit [31:0] up, input bit v, input bit b,
                         input bit j, input bit t, input bit [31:0] tgt, input bit m);
        exp_t e;
        bit   tk;
        bit [31:0] tg, nx;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        pc             = p;
        upd_valid      = v;
        upd_pc         = up;
        upd_is_branch  = b;
        upd_is_jump    = j;
        upd_taken      = t;
        upd_target     = tgt;
        upd_mispredict = m;
        e.pc = p;
        for (int k = 0; k < 2; k++) begin
            predict(k, p, tk, tg, nx);
            e.tk[k]  = tk;
            e.tgt[k] = tg;
            e.nxt[k] = nx;
            e.brc[k] = 32'(m_brc[k]);
            e.mpc[k] = 32'(m_mpc[k]);
        end
        exp_q.push_back(e);
        for (int k = 0; k < 2; k++) model_update(k, v, up, b, j, t, tgt, m);
    endtask

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got tk=%b tgt=%h nxt=%h brc=%h mpc=%h, expected tk=%b tgt=%h nxt=%h brc=%h mpc=%h",
                     name, act.tk, act.tgt, act.nxt, act.brc, act.mpc,
                     exp.tk, exp.tgt, exp.nxt, exp.brc, exp.mpc);
        end
    endtask

    // Monitor: outputs are combinational, so every issued lookup is compared mid-cycle.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.pc     = pc;
                a.tk     = {pt_b, pt_g};
                a.tgt[0] = tg_g;
                a.tgt[1] = tg_b;
                a.nxt[0] = np_g;
                a.nxt[1] = np_b;
                a.brc[0] = 32'(bc_g);
                a.brc[1] = 32'(bc_b);
                a.mpc[0] = 32'(mc_g);
                a.mpc[1] = 32'(mc_b);
                check($sformatf("vec%0d pc=%h", n_vec, e.pc), a, e);
            end
        end
    end

    function automatic bit [31:0] rand_pc();
        bit [31:0] upper;
        bit [31:0] idx;
        case ($urandom_range(0, 3))
            0:       upper = 32'h0;
            1:       upper = 32'h1;
            2:       upper = 32'h2;
            default: upper = 32'h1FF_FFFF;
        endcase
        idx = 32'($urandom_range(0, 7));
        if (idx == 7) idx = 31;
        return (upper << 7) | (idx << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        bit        b, j, t, v, m;
        bit [31:0] p, up;
        reset = 1'b1; pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_is_branch = 1'b0;
        upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;

        // Reset wins over a simultaneous taken-branch update.
        step(1, 32'h40, 1, 1, 0, 1, 32'h20, 0);
        step(0, 32'h40, 0, 0, 0, 0, 32'h0, 0);
        // Train a taken branch; same-cycle lookup still sees the old contents.
        step(0, 32'h40, 1, 1, 0, 1, 32'h20, 0);
        step(0, 32'h40, 0, 0, 0, 0, 32'h0, 0);
        // jal, then the next-cycle lookup redirects.
        step(0, 32'h100, 1, 0, 1, 1, 32'h200, 0);
        step(0, 32'h100, 0, 0, 0, 0, 32'h0, 0);
        // Saturate up, then walk down with lookups between updates.
        repeat (4) step(0, 32'h40, 1, 1, 0, 1, 32'h20, 0);
        step(0, 32'h40, 0, 0, 0, 0, 32'h0, 0);
        step(0, 32'h40, 1, 1, 0, 0, 32'h0, 0);
        step(0, 32'h40, 0, 0, 0, 0, 32'h0, 0);
        step(0, 32'h40, 1, 1, 0, 0, 32'h0, 0);
        step(0, 32'h40, 0, 0, 0, 0, 32'h0, 0);
        // Tag conflict: 0xC0 aliases slot 0x10 and evicts 0x40.
        step2(32'h40, 32'hC0, 1, 1, 0, 1, 32'h300, 1);
        step(0, 32'h40, 0, 0, 0, 0, 32'h0, 0);
        step(0, 32'hC0, 0, 0, 0, 0, 32'h0, 0);
        // Drive the 4-bit counters past saturation; both flags set acts as a jump.
        repeat (20) step2(32'h40, 32'h80, 1, 1, 1, 1, 32'h400, 1);
        step(0, 32'h80, 0, 0, 0, 0, 32'h0, 0);
        // Non-qualifying mispredict and upd_valid=0 must not change anything.
        step2(32'h40, 32'h40, 1, 0, 0, 1, 32'h500, 1);
        step2(32'h40, 32'h40, 0, 1, 0, 1, 32'h500, 1);
        // Wrap-around at the top of the address space.
        step(0, 32'hFFFF_FFFC, 1, 1, 0, 0, 32'h0, 0);
        step(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0, 0);
        // Mid-run reset discards training.
        step(1, 32'h40, 0, 0, 0, 0, 32'h0, 0);
        step(0, 32'h40, 0, 0, 0, 0, 32'h0, 0);
        step(0, 32'h100, 0, 0, 0, 0, 32'h0, 0);

        for (int n = 0; n < 1500; n++) begin
            p  = rand_pc();
            up = ($urandom_range(0, 1) == 0) ? p : rand_pc();
            v  = ($urandom_range(0, 3) != 0);
            j  = ($urandom_range(0, 4) == 0);
            b  = ($urandom_range(0, 4) != 0);
            t  = j ? ($urandom_range(0, 7) != 0) : bit'($urandom_range(0, 1));
            m  = bit'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) step(1, p, v, b, j, t, $urandom(), m);
            else step2(p, up, v, b, j, t, $urandom(), m);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
